// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between the IF/MEM stage ports, the arbiter and the
// unified memory macro. The arbiter takes the slave view; the pipeline/memory side takes master.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [DATA_W-1:0] dm_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-ported memory between fetch and data ports.
// Data has priority; a bounded data-run counter forces a fetch grant so fetch never starves.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int MAX_DM_RUN = 4
) (
    input  logic             clk,
    input  logic             reset,
    mem_port_arbiter_if.slave bus
);
    localparam int RUN_W = $clog2(MAX_DM_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DM_RUN);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arbStateT;

    arbStateT          state;
    arbStateT          nextState;
    logic              ownerDm;
    logic              weReg;
    logic [ADDR_W-1:0] addrReg;
    logic [DATA_W-1:0] wdataReg;
    logic [3:0]        cnt;
    logic [RUN_W-1:0]  dmRun;

    logic forceFetch;
    logic pickDm;
    logic pickIf;

    function automatic logic [RUN_W-1:0] satInc(input logic [RUN_W-1:0] v);
        return (v == RUN_MAX) ? v : v + 1'b1;
    endfunction

    assign forceFetch = bus.if_req && bus.dm_req && (dmRun == RUN_MAX);
    assign pickDm     = bus.dm_req && !forceFetch;
    assign pickIf     = bus.if_req && !pickDm;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:    if (pickDm || pickIf) nextState = ISSUE;
            ISSUE:   nextState = (MEM_LAT == 1) ? RESP : WAIT;
            WAIT:    if (cnt == 4'd1) nextState = RESP;
            RESP:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Transaction latch, latency counter and data-run bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            ownerDm  <= 1'b0;
            weReg    <= 1'b0;
            addrReg  <= '0;
            wdataReg <= '0;
            cnt      <= '0;
            dmRun    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pickDm) begin
                        ownerDm  <= 1'b1;
                        weReg    <= bus.dm_we;
                        addrReg  <= bus.dm_addr;
                        wdataReg <= bus.dm_wdata;
                    end else if (pickIf) begin
                        ownerDm  <= 1'b0;
                        weReg    <= 1'b0;
                        addrReg  <= bus.if_addr;
                        wdataReg <= '0;
                    end
                end
                ISSUE: begin
                    cnt <= 4'(MEM_LAT - 1);
                    if (ownerDm && bus.if_req) begin
                        dmRun <= satInc(dmRun);
                    end else begin
                        dmRun <= '0;
                    end
                end
                WAIT:    cnt <= cnt - 4'd1;
                default: ;
            endcase
        end
    end

    // Outputs decode purely from state and latched transaction; no path from the request inputs
    always_comb begin
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.if_gnt    = 1'b0;
        bus.dm_gnt    = 1'b0;
        bus.if_rvalid = 1'b0;
        bus.dm_rvalid = 1'b0;
        bus.if_rdata  = '0;
        bus.dm_rdata  = '0;
        bus.mem_addr  = addrReg;
        bus.mem_wdata = wdataReg;
        bus.busy      = (state != IDLE);
        if (state == ISSUE) begin
            bus.mem_req = 1'b1;
            bus.mem_we  = weReg;
            bus.if_gnt  = !ownerDm;
            bus.dm_gnt  = ownerDm;
        end
        if (state == RESP) begin
            bus.if_rvalid = !ownerDm;
            bus.dm_rvalid = ownerDm;
            if (!ownerDm) begin
                bus.if_rdata = bus.mem_rdata;
            end else if (!weReg) begin
                bus.dm_rdata = bus.mem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: MEM_LAT=2 instance for most cases,
// a MEM_LAT=1 instance for back-to-back fetch spacing.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus2();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .MAX_DM_RUN(4)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2.slave)
    );
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .MAX_DM_RUN(4)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave)
    );

    task automatic chkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] baseVal(input logic [31:0] a);
        case (a)
            32'h10:  return 32'h0050_0093;
            32'h100: return 32'h1111_2222;
            default: return ~a;
        endcase
    endfunction

    // Memory models: read data valid only in the cycle MEM_LAT after mem_req
    bit          wrValid [0:255];
    logic [31:0] wrData  [0:255];
    int          left2 = 0;
    int          left1 = 0;
    logic [31:0] addr2 = '0;
    logic [31:0] addr1 = '0;

    always @(posedge clk) begin
        if (bus2.mem_req) begin
            left2 <= 2;
            addr2 <= bus2.mem_addr;
            if (bus2.mem_we) begin
                wrValid[bus2.mem_addr[9:2]] <= 1'b1;
                wrData[bus2.mem_addr[9:2]]  <= bus2.mem_wdata;
            end
        end else if (left2 > 0) begin
            left2 <= left2 - 1;
        end
    end

    always @(posedge clk) begin
        if (bus1.mem_req) begin
            left1 <= 1;
            addr1 <= bus1.mem_addr;
        end else if (left1 > 0) begin
            left1 <= left1 - 1;
        end
    end

    assign bus2.mem_rdata = (left2 == 1) ? (wrValid[addr2[9:2]] ? wrData[addr2[9:2]] : baseVal(addr2))
                                         : 32'hBAD0_BAD0;
    assign bus1.mem_rdata = (left1 == 1) ? baseVal(addr1) : 32'hBAD0_BAD0;

    always @(negedge clk) begin
        if (!reset) begin
            chkEq("gnt_excl",    32'(bus2.if_gnt & bus2.dm_gnt), 32'd0);
            chkEq("rvalid_excl", 32'(bus2.if_rvalid & bus2.dm_rvalid), 32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic waitIdle2(input string tag);
        for (int k = 0; k < 20 && bus2.busy; k++) step();
        chkEq(tag, 32'(bus2.busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [9:0] order;
        int n;
        int lastG;
        int rvN;
        bit prevF;

        bus2.if_req = 0; bus2.if_addr = '0; bus2.dm_req = 0; bus2.dm_we = 0;
        bus2.dm_addr = '0; bus2.dm_wdata = '0;
        bus1.if_req = 0; bus1.if_addr = '0; bus1.dm_req = 0; bus1.dm_we = 0;
        bus1.dm_addr = '0; bus1.dm_wdata = '0;
        order = '0;

        reset = 1'b1;
        repeat (3) step();
        chkEq("rst_busy",  32'(bus2.busy), 32'd0);
        chkEq("rst_ctl",   32'({bus2.if_gnt, bus2.dm_gnt, bus2.mem_req, bus2.mem_we,
                                bus2.if_rvalid, bus2.dm_rvalid}), 32'd0);
        chkEq("rst_addr",  bus2.mem_addr, 32'd0);
        chkEq("rst_wdata", bus2.mem_wdata, 32'd0);
        chkEq("rst_rdata", bus2.if_rdata | bus2.dm_rdata, 32'd0);
        chkEq("rst_run",   32'(dut2.dmRun), 32'd0);
        reset = 1'b0;
        step();

        // Single fetch
        bus2.if_req = 1; bus2.if_addr = 32'h10;
        step();
        chkEq("f1_gnt",  32'({bus2.if_gnt, bus2.dm_gnt, bus2.mem_req}), 32'b101);
        chkEq("f1_addr", bus2.mem_addr, 32'h10);
        chkEq("f1_we",   32'(bus2.mem_we), 32'd0);
        step();
        chkEq("f1_wait", 32'({bus2.if_gnt, bus2.if_rvalid, bus2.busy}), 32'b001);
        step();
        chkEq("f1_rvalid", 32'(bus2.if_rvalid), 32'd1);
        chkEq("f1_rdata",  bus2.if_rdata, 32'h0050_0093);
        bus2.if_req = 0;
        step();
        chkEq("f1_idle",   32'({bus2.busy, bus2.if_rvalid}), 32'd0);
        chkEq("f1_rdata0", bus2.if_rdata, 32'd0);

        // Simultaneous requests: data first, fetch at cycle 5
        bus2.if_req = 1; bus2.if_addr = 32'h10;
        bus2.dm_req = 1; bus2.dm_we = 0; bus2.dm_addr = 32'h100;
        step();
        chkEq("sim_dgnt", 32'({bus2.if_gnt, bus2.dm_gnt}), 32'b01);
        chkEq("sim_addr", bus2.mem_addr, 32'h100);
        step(); step();
        chkEq("sim_drv",    32'({bus2.if_rvalid, bus2.dm_rvalid}), 32'b01);
        chkEq("sim_drdata", bus2.dm_rdata, 32'h1111_2222);
        chkEq("sim_irdata", bus2.if_rdata, 32'd0);
        bus2.dm_req = 0;
        step();
        chkEq("sim_idle4", 32'({bus2.busy, bus2.if_gnt}), 32'd0);
        step();
        chkEq("sim_fgnt",  32'({bus2.if_gnt, bus2.dm_gnt}), 32'b10);
        chkEq("sim_faddr", bus2.mem_addr, 32'h10);
        step(); step();
        chkEq("sim_frv",    32'({bus2.if_rvalid, bus2.dm_rvalid}), 32'b10);
        chkEq("sim_frdata", bus2.if_rdata, 32'h0050_0093);
        bus2.if_req = 0;
        step();

        // Starvation guard: both held high
        bus2.if_req = 1; bus2.if_addr = 32'h10;
        bus2.dm_req = 1; bus2.dm_we = 0; bus2.dm_addr = 32'h300;
        n = 0; lastG = 0; prevF = 0;
        for (int k = 0; k < 80 && n < 10; k++) begin
            step();
            if (prevF) begin
                chkEq("run_clear", 32'(dut2.dmRun), 32'd0);
                prevF = 0;
            end
            if (bus2.dm_gnt || bus2.if_gnt) begin
                order[9-n] = bus2.dm_gnt;
                if (n > 0) chkEq("run_gap", 32'(cyc - lastG), 32'd4);
                lastG = cyc;
                prevF = bus2.if_gnt;
                n++;
                if (n == 10) begin
                    bus2.if_req = 0;
                    bus2.dm_req = 0;
                end
            end
        end
        step();
        chkEq("run_clear_last", 32'(dut2.dmRun), 32'd0);
        chkEq("run_count", 32'(n), 32'd10);
        chkEq("run_order", 32'(order), 32'(10'b1111011110));
        waitIdle2("run_done");

        // Store then load back
        bus2.dm_req = 1; bus2.dm_we = 1; bus2.dm_addr = 32'h200; bus2.dm_wdata = 32'hDEAD_BEEF;
        step();
        chkEq("st_gnt",   32'({bus2.dm_gnt, bus2.mem_req, bus2.mem_we}), 32'b111);
        chkEq("st_addr",  bus2.mem_addr, 32'h200);
        chkEq("st_wdata", bus2.mem_wdata, 32'hDEAD_BEEF);
        step();
        chkEq("st_we_q",  32'(bus2.mem_we), 32'd0);
        step();
        chkEq("st_rv",    32'(bus2.dm_rvalid), 32'd1);
        chkEq("st_rdata", bus2.dm_rdata, 32'd0);
        bus2.dm_req = 0; bus2.dm_we = 0; bus2.dm_wdata = '0;
        step();
        bus2.dm_req = 1; bus2.dm_addr = 32'h200;
        step(); step(); step();
        chkEq("ld_back_rv",   32'(bus2.dm_rvalid), 32'd1);
        chkEq("ld_back_data", bus2.dm_rdata, 32'hDEAD_BEEF);
        bus2.dm_req = 0;
        step();

        // Reset during WAIT
        bus2.if_req = 1; bus2.if_addr = 32'h40;
        step();
        chkEq("rw_gnt", 32'(bus2.if_gnt), 32'd1);
        step();
        reset = 1'b1;
        bus2.if_req = 0;
        step();
        chkEq("rw_busy", 32'(bus2.busy), 32'd0);
        chkEq("rw_ctl",  32'({bus2.if_gnt, bus2.dm_gnt, bus2.mem_req, bus2.mem_we,
                              bus2.if_rvalid, bus2.dm_rvalid}), 32'd0);
        chkEq("rw_addr", bus2.mem_addr, 32'd0);
        chkEq("rw_data", bus2.if_rdata | bus2.dm_rdata | bus2.mem_wdata, 32'd0);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chkEq("rw_norv", 32'({bus2.if_rvalid, bus2.dm_rvalid}), 32'd0);
        end
        bus2.if_req = 1; bus2.if_addr = 32'h40;
        step();
        chkEq("rw2_gnt", 32'(bus2.if_gnt), 32'd1);
        step(); step();
        chkEq("rw2_rv",    32'(bus2.if_rvalid), 32'd1);
        chkEq("rw2_rdata", bus2.if_rdata, 32'hFFFF_FFBF);
        bus2.if_req = 0;
        step();

        // MEM_LAT=1 back-to-back fetches
        bus1.if_req = 1; bus1.if_addr = 32'h80;
        n = 0; rvN = 0; lastG = 0;
        for (int k = 0; k < 40 && rvN < 3; k++) begin
            step();
            if (bus1.if_rvalid) begin
                chkEq("l1_rv_lat",  32'(cyc - lastG), 32'd1);
                chkEq("l1_rdata",   bus1.if_rdata, 32'hFFFF_FF7F);
                rvN++;
            end
            if (bus1.if_gnt) begin
                if (n > 0) chkEq("l1_gap", 32'(cyc - lastG), 32'd3);
                lastG = cyc;
                n++;
                if (n == 3) bus1.if_req = 0;
            end
        end
        chkEq("l1_gnts", 32'(n), 32'd3);
        chkEq("l1_rvs",  32'(rvN), 32'd3);
        step();
        chkEq("l1_idle", 32'(bus1.busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
